// File: rtl/nt_pkg.sv
// Shared defaults and types for the neighbour-tracker ingress scheduler.
package nt_pkg;

  localparam int DEF_IDX_W     = 13;
  localparam int DEF_TRACE_W   = 32;
  localparam int DEF_HAZ_DEPTH = 4;

  // History entries are sized by the package default index width.
  typedef struct packed {
    logic                 valid;
    logic [DEF_IDX_W-1:0] idx;
  } hist_entry_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DRAIN_WAIT = 2'd1,
    DRAINED    = 2'd2
  } sched_state_t;

endpackage

// File: rtl/nt_ingress_scheduler_if.sv
// Request bus from the trace sources plus the single issue port toward the tracker.
interface nt_ingress_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = nt_pkg::DEF_IDX_W,
  parameter int TRACE_W = nt_pkg::DEF_TRACE_W
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*TRACE_W-1:0] req_trace;
  logic [NUM_REQ*IDX_W-1:0]   req_index;
  logic                       out_valid;
  logic [TRACE_W-1:0]         out_trace;
  logic [IDX_W-1:0]           out_index;

  modport master (
    output req_valid, req_trace, req_index,
    input  req_ready, out_valid, out_trace, out_index
  );

  modport slave (
    input  req_valid, req_trace, req_index,
    output req_ready, out_valid, out_trace, out_index
  );
endinterface

// File: rtl/nt_rr_arbiter.sv
// Round-robin pick over an eligibility mask; search starts one past the last winner.
module nt_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr_reg;

  always_comb begin
    int   cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(rr_ptr_reg) + off) % NUM_REQ;
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= PTR_W'(NUM_REQ - 1);
    end else if (advance) begin
      rr_ptr_reg <= grant_idx;
    end
  end
endmodule

// File: rtl/nt_ingress_scheduler.sv
// Arbitrates trace sources onto the tracker input, holding back indices still in the
// tracker's read-modify-write window, with a drain handshake for URAM sweeps.
module nt_ingress_scheduler
  import nt_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int TRACE_W   = DEF_TRACE_W,
  parameter int HAZ_DEPTH = DEF_HAZ_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  nt_ingress_scheduler_if.slave        bus,
  input  logic                         drain_req,
  output logic                         drain_done,
  output logic                         idle,
  output logic [31:0]                  stall_count
);
  localparam int PTR_W = $clog2(NUM_REQ);

  sched_state_t       state_reg, state_next;
  hist_entry_t        hist_reg [HAZ_DEPTH];
  logic               out_valid_reg;
  logic [TRACE_W-1:0] out_trace_reg;
  logic [IDX_W-1:0]   out_index_reg;
  logic [31:0]        stall_count_reg;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               transfer;
  logic               issue_en;
  logic               hist_busy;
  logic               quiet;

  // The first cycle drain_req is seen already blocks grants.
  assign issue_en = !reset && (state_reg == RUN) && !drain_req;

  always_comb begin
    hist_busy = 1'b0;
    for (int h = 0; h < HAZ_DEPTH; h++) begin
      hist_busy = hist_busy | hist_reg[h].valid;
    end
  end

  assign quiet = !out_valid_reg && !hist_busy;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      logic [IDX_W-1:0] idx;
      logic             hazard;
      assign idx = bus.req_index[gi*IDX_W +: IDX_W];
      always_comb begin
        hazard = out_valid_reg && (out_index_reg == idx);
        for (int h = 0; h < HAZ_DEPTH; h++) begin
          if (hist_reg[h].valid && (hist_reg[h].idx == DEF_IDX_W'(idx))) begin
            hazard = 1'b1;
          end
        end
      end
      assign eligible[gi] = issue_en && bus.req_valid[gi] && !hazard;
    end
  endgenerate

  nt_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .eligible  (eligible),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign transfer = |grant;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RUN:        if (drain_req) state_next = DRAIN_WAIT;
      DRAIN_WAIT: begin
        if (!drain_req)  state_next = RUN;
        else if (quiet)  state_next = DRAINED;
      end
      DRAINED:    if (!drain_req) state_next = RUN;
      default:    state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RUN;
      out_valid_reg   <= 1'b0;
      out_trace_reg   <= '0;
      out_index_reg   <= '0;
      stall_count_reg <= '0;
      for (int h = 0; h < HAZ_DEPTH; h++) begin
        hist_reg[h] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= transfer;
      if (transfer) begin
        out_trace_reg <= bus.req_trace[int'(grant_idx)*TRACE_W +: TRACE_W];
        out_index_reg <= bus.req_index[int'(grant_idx)*IDX_W +: IDX_W];
      end
      hist_reg[0] <= '{valid: out_valid_reg, idx: DEF_IDX_W'(out_index_reg)};
      for (int h = 1; h < HAZ_DEPTH; h++) begin
        hist_reg[h] <= hist_reg[h-1];
      end
      if ((|bus.req_valid) && !transfer && (stall_count_reg != 32'hFFFF_FFFF)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_trace = out_trace_reg;
  assign bus.out_index = out_index_reg;
  assign drain_done    = (state_reg == DRAINED);
  assign idle          = !reset && quiet;
  assign stall_count   = stall_count_reg;
endmodule

// File: tb/tb_nt_ingress_scheduler.sv
// Randomised and directed stimulus for nt_ingress_scheduler, checked each cycle
// against a model that tracks issue times rather than pipeline registers.
module tb_nt_ingress_scheduler;
  localparam int NUM_REQ   = 2;
  localparam int IDX_W     = 13;
  localparam int TRACE_W   = 32;
  localparam int HAZ_DEPTH = 4;

  localparam int M_RUN     = 0;
  localparam int M_WAIT    = 1;
  localparam int M_DRAINED = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drain_req = 1'b0;
  logic        drain_done;
  logic        idle;
  logic [31:0] stall_count;

  nt_ingress_scheduler_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TRACE_W(TRACE_W)) bus ();

  nt_ingress_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .IDX_W     (IDX_W),
    .TRACE_W   (TRACE_W),
    .HAZ_DEPTH (HAZ_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .idle        (idle),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [TRACE_W-1:0] trace;
  } req_t;

  typedef struct {
    int cyc;
    int idx;
  } issue_t;

  req_t        rq [NUM_REQ][$];
  issue_t      log_q [$];
  int          cyc;
  int          n_checks;
  int          n_fails;
  int          m_rr;
  int          m_mode;
  int          m_win;
  bit          m_out_valid;
  logic [TRACE_W-1:0] m_out_trace;
  int          m_out_index;
  logic [31:0] m_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    log_q.delete();
    m_rr        = NUM_REQ - 1;
    m_mode      = M_RUN;
    m_out_valid = 1'b0;
    m_out_trace = '0;
    m_out_index = 0;
    m_stall     = '0;
  endtask

  task automatic push(input int r, input int idx);
    req_t e;
    e.idx   = idx;
    e.trace = $urandom;
    rq[r].push_back(e);
  endtask

  function automatic int pending();
    int n = 0;
    for (int r = 0; r < NUM_REQ; r++) n += rq[r].size();
    return n;
  endfunction

  // An index presented on out_* at cycle c stays blocked through c + HAZ_DEPTH.
  function automatic bit blocked(input int idx);
    foreach (log_q[i]) begin
      if (log_q[i].idx == idx && (cyc - log_q[i].cyc) <= HAZ_DEPTH) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic present();
    logic [NUM_REQ-1:0]         v;
    logic [NUM_REQ*TRACE_W-1:0] t;
    logic [NUM_REQ*IDX_W-1:0]   x;
    v = '0;
    t = '0;
    x = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rq[r].size() > 0) begin
        v[r] = 1'b1;
        t[r*TRACE_W +: TRACE_W] = rq[r][0].trace;
        x[r*IDX_W +: IDX_W]     = IDX_W'(rq[r][0].idx);
      end
    end
    bus.req_valid = v;
    bus.req_trace = t;
    bus.req_index = x;
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] exp_ready;
    bit any_valid;
    bit exp_idle;
    issue_t e;
    present();
    #1;
    while (log_q.size() > 0 && (cyc - log_q[0].cyc) > HAZ_DEPTH) void'(log_q.pop_front());
    exp_idle  = (log_q.size() == 0);
    any_valid = 1'b0;
    m_win     = -1;
    for (int r = 0; r < NUM_REQ; r++) if (rq[r].size() > 0) any_valid = 1'b1;
    if (m_mode == M_RUN && !drain_req) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int r;
        r = (m_rr + k) % NUM_REQ;
        if (m_win < 0 && rq[r].size() > 0 && !blocked(rq[r][0].idx)) m_win = r;
      end
    end
    exp_ready = '0;
    if (m_win >= 0) exp_ready[m_win] = 1'b1;

    check_eq("req_ready",   bus.req_ready, exp_ready);
    check_eq("out_valid",   bus.out_valid, m_out_valid);
    check_eq("out_index",   bus.out_index, m_out_index);
    check_eq("out_trace",   bus.out_trace, m_out_trace);
    check_eq("idle",        idle, exp_idle);
    check_eq("drain_done",  drain_done, m_mode == M_DRAINED);
    check_eq("stall_count", stall_count, m_stall);

    if (m_win >= 0) begin
      $display("cycle %0d: grant r%0d index %0d trace %08h", cyc, m_win,
               rq[m_win][0].idx, rq[m_win][0].trace);
      m_out_trace = rq[m_win][0].trace;
      m_out_index = rq[m_win][0].idx;
      m_rr        = m_win;
      e.cyc       = cyc + 1;
      e.idx       = rq[m_win][0].idx;
      log_q.push_back(e);
      void'(rq[m_win].pop_front());
    end
    m_out_valid = (m_win >= 0);
    if (any_valid && m_win < 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    case (m_mode)
      M_RUN:     if (drain_req) m_mode = M_WAIT;
      M_WAIT: begin
        if (!drain_req)    m_mode = M_RUN;
        else if (exp_idle) m_mode = M_DRAINED;
      end
      M_DRAINED: if (!drain_req) m_mode = M_RUN;
      default:   m_mode = M_RUN;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_queues(input string tag, input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_left"}, pending(), 0);
    for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
  endtask

  task automatic settle();
    repeat (HAZ_DEPTH + 2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0;
    n_fails  = 0;
    cyc      = 0;
    bus.req_valid = '0;
    bus.req_trace = '0;
    bus.req_index = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_idle",      idle, 0);
    check_eq("rst_stall",     stall_count, 0);
    reset = 1'b0;

    // single requester, consecutive indices
    push(0, 5); push(0, 6); push(0, 7);
    run_queues("seq", 20);
    settle();

    // two requesters holding distinct indices
    for (int i = 0; i < 6; i++) begin
      push(0, 10);
      push(1, 20);
    end
    run_queues("alt", 100);
    settle();

    // repeated index from one requester with a bystander
    push(0, 33); push(0, 33); push(1, 40);
    run_queues("rehit", 30);
    settle();

    // same index from both with the pointer at NUM_REQ-1
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(0, 7); push(1, 7);
    run_queues("same_idx", 30);
    settle();

    // drain with three issues in flight
    push(0, 100); push(0, 101); push(0, 102);
    run_queues("pre_drain", 20);
    drain_req = 1'b1;
    push(1, 300);
    n = 0;
    while (drain_done !== 1'b1 && n < HAZ_DEPTH + 4) begin
      step();
      n++;
    end
    check_eq("drain_latency_ok", n <= HAZ_DEPTH + 2, 1);
    repeat (2) step();
    drain_req = 1'b0;
    step();
    run_queues("resume", 10);
    settle();

    // reset while waiting for drain with history live
    push(0, 50); push(0, 51);
    run_queues("pre_rst", 10);
    drain_req = 1'b1;
    step();
    step();
    push(0, 51);
    present();
    reset = 1'b1;
    #1;
    check_eq("rst_mid_out_valid",  bus.out_valid, 0);
    check_eq("rst_mid_out_index",  bus.out_index, 0);
    check_eq("rst_mid_out_trace",  bus.out_trace, 0);
    check_eq("rst_mid_req_ready",  bus.req_ready, 0);
    check_eq("rst_mid_idle",       idle, 0);
    check_eq("rst_mid_drain_done", drain_done, 0);
    check_eq("rst_mid_stall",      stall_count, 0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    drain_req = 1'b0;
    model_reset();
    step();
    check_eq("post_rst_out_index", bus.out_index, 51);
    run_queues("post_rst", 10);
    settle();

    // random traffic over a small index set with occasional drains
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (rq[r].size() == 0 && $urandom_range(0, 2) != 0) push(r, $urandom_range(0, 7));
      end
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      step();
    end
    drain_req = 1'b0;
    run_queues("final", 100);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/nt_ingress_scheduler.md
Name: nt_ingress_scheduler

Overview:
- Front-end scheduler for the neighbour tracker. Arbitrates NUM_REQ trace sources, one per cycle, onto the tracker's single trace/index input.
- Stalls any request whose index is still in flight in the tracker read-modify-write pipeline. This keeps URAM read-after-write order intact.
- Provides a drain handshake so software or readout logic can quiesce the tracker before sweeping the URAM.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDX_W, 13, hash table index width.
- TRACE_W, 32, trace word width.
- HAZ_DEPTH, 4, cycles an issued index stays blocked, counted from its presentation on out_*.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready (combinational grant)
- req_trace  in  NUM_REQ*TRACE_W  packed traces; requester r at [r*TRACE_W +: TRACE_W]
- req_index  in  NUM_REQ*IDX_W  packed indices; same packing
- out_valid  out  1  drives tracker trace_valid and index_valid
- out_trace  out  TRACE_W  to tracker trace
- out_index  out  IDX_W  to tracker index
- drain_req  in  1  level request to quiesce
- drain_done  out  1  high while quiesced
- idle  out  1  no issue in flight
- stall_count  out  32  saturating count of cycles with at least one valid request but no grant

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All outputs are 0 during reset.
- After reset: state RUN, rr_ptr = NUM_REQ-1, history all invalid, stall_count = 0.

Handshake:
- A transfer happens when req_valid[r] && req_ready[r].
- At most one req_ready bit is high per cycle.
- req_ready never depends on req_valid of the same requester beyond eligibility.
- Requesters hold trace and index stable until the transfer.

Eligibility:
- Requester r is eligible when all of these hold: state == RUN; req_valid[r]; req_index[r] matches no valid history entry; req_index[r] does not equal out_index while out_valid = 1.

Arbitration:
- Round-robin among eligible requesters, starting at rr_ptr+1 modulo NUM_REQ.
- A hazarded requester is skipped; a later eligible requester may win.
- rr_ptr updates to the winner only on a transfer.

Issue:
- The winner's trace and index are registered into out_* at the next edge, with out_valid = 1. Latency from transfer to out_valid is 1 cycle.
- With no transfer, out_valid = 0. out_trace and out_index hold their previous values.

History:
- Shift register of HAZ_DEPTH entries {valid, index}.
- Entry 0 loads {out_valid, out_index} every cycle; older entries shift toward HAZ_DEPTH-1.
- An issued index is therefore blocked for HAZ_DEPTH+1 cycles after its transfer cycle, counting the out_* cycle.
- Back-to-back requests with different indices issue every cycle.

idle:
- idle = !out_valid && no valid history entry.

stall_count:
- Increments when any req_valid is high and no transfer occurs. This includes drain stalls.
- Saturates at 0xFFFF_FFFF.

State machine:
- RUN → DRAIN_WAIT when drain_req = 1. No grants in the cycle drain_req is first seen.
- DRAIN_WAIT → DRAINED when idle = 1. drain_done is registered and goes high on entry to DRAINED.
- DRAIN_WAIT → RUN if drain_req drops before idle.
- DRAINED → RUN when drain_req = 0. drain_done clears on the same edge.
- No grants are issued in DRAIN_WAIT or DRAINED.

Boundary conditions:
- All requesters hazarded: no grant, stall_count increments.
- Same index from two requesters in the same cycle: only the winner transfers. The other becomes hazarded next cycle.
- Reset mid-drain: returns to RUN with history cleared.

Decomposition:
- Package nt_pkg holds IDX_W, TRACE_W and HAZ_DEPTH defaults, typedef hist_entry_t {logic valid; logic [IDX_W-1:0] idx;}, and typedef enum sched_state_t {RUN, DRAIN_WAIT, DRAINED}.
- One sub-module, nt_rr_arbiter: NUM_REQ-wide round-robin over an eligibility mask, with outputs grant one-hot and grant_idx, plus rr_ptr update on an advance input.

Test Plan:
- Single requester 0, indices 5,6,7 on consecutive cycles → out_valid high 3 consecutive cycles with out_index 5,6,7, each 1 cycle after its transfer; idle returns to 1 HAZ_DEPTH+1 cycles after the last.
- Both requesters valid, distinct indices 10/20, held continuously → grants alternate r0,r1,r0,r1; out_index alternates 10,20,10,20 only where not hazarded. Index 10 is re-issued no sooner than 5 cycles after its previous out_valid.
- Requester 0 issues index 33 then immediately requests 33 again; requester 1 requests 40 → r1 granted in the interim, r0's second 33 is granted exactly HAZ_DEPTH+1 cycles after its first out_valid, and stall_count increments during the blocked cycles.
- Same index 7 from both requesters in one cycle, rr_ptr = 1 → r0 wins; r1 stalls for the hazard window, then is granted.
- drain_req raised while 3 issues are in flight → no further req_ready; drain_done rises within HAZ_DEPTH+2 cycles once idle; drain_req drop → drain_done = 0 and grants resume the next cycle.
- Reset asserted in DRAIN_WAIT with history valid → all outputs 0 immediately; after release, state RUN and a request for a previously in-flight index is granted the first cycle.
